// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between multicycle_ctrl and the MIPS datapath
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int RET_CNT_W = 32
);
  logic [5:0]           opcode;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 ir_write;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           pc_src;
  logic                 ext_op;
  logic                 illegal;
  logic                 mem_timeout;
  logic [RET_CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, ext_op, illegal, mem_timeout, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, ext_op, illegal, mem_timeout, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory stall, timeout and retire count
// Optional bne decode is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RET_CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_op;
  } ctl_t;

  state_t               st, nxt;
  ctl_t                 ctl;
  logic [5:0]           op_q;
  logic [CW-1:0]        wait_cnt;
  logic [RET_CNT_W-1:0] ret_q;
  logic                 at_limit, timeout, retire, bad_op, bne_q, run;

  // Per-state select values; registered one cycle ahead from the next state.
  function automatic ctl_t state_ctl(state_t s, logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      DECODE:   begin c.alu_src_b = 2'd3; c.ext_op = 1'b1; end
      MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.ext_op = 1'b1; end
      MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
      R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.ext_op    = (op != OP_ORI);
        c.alu_op    = (op == OP_ORI) ? 2'd3 : 2'd0;
      end
      I_WB:     c.reg_write = 1'b1;
      BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; end
      JUMP:     begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign at_limit = (wait_cnt == CW'(MEM_WAIT_MAX));

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign bne_q = (op_q == OP_BNE);
`else
  assign bne_q = 1'b0;
`endif

  always_comb begin
    nxt     = st;
    timeout = 1'b0;
    retire  = 1'b0;
    bad_op  = 1'b0;
    case (st)
      FETCH: begin
        if (bus.mem_ready) nxt = DECODE;
        else if (at_limit) timeout = 1'b1;
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:    nxt = MEM_ADDR;
          OP_R:            nxt = R_EXEC;
          OP_ADDI, OP_ORI: nxt = I_EXEC;
          OP_BEQ:          nxt = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:          nxt = BRANCH;
`endif
          OP_J:            nxt = JUMP;
          default: begin
            nxt    = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: nxt = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (bus.mem_ready) nxt = MEM_WB;
        else if (at_limit) begin nxt = FETCH; timeout = 1'b1; end
      end
      MEM_WB: begin nxt = FETCH; retire = 1'b1; end
      MEM_WR: begin
        if (bus.mem_ready) begin nxt = FETCH; retire = 1'b1; end
        else if (at_limit) begin nxt = FETCH; timeout = 1'b1; end
      end
      R_EXEC: nxt = R_WB;
      R_WB:   begin nxt = FETCH; retire = 1'b1; end
      I_EXEC: nxt = I_WB;
      I_WB:   begin nxt = FETCH; retire = 1'b1; end
      BRANCH: begin nxt = FETCH; retire = 1'b1; end
      JUMP:   begin nxt = FETCH; retire = 1'b1; end
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= FETCH;
      ctl      <= state_ctl(FETCH, 6'd0);
      op_q     <= '0;
      wait_cnt <= '0;
      ret_q    <= '0;
    end else begin
      st  <= nxt;
      ctl <= state_ctl(nxt, (st == DECODE) ? bus.opcode : op_q);
      if (st == DECODE) op_q <= bus.opcode;
      // A timeout in FETCH re-enters FETCH, so it also restarts the wait count.
      if (nxt != st || timeout) wait_cnt <= '0;
      else if (!bus.mem_ready) wait_cnt <= wait_cnt + CW'(1);
      if (retire) ret_q <= ret_q + RET_CNT_W'(1);
    end
  end

  assign run = ~rst;

  assign bus.pc_write      = run & (ctl.pc_write | ((st == FETCH) & bus.mem_ready));
  assign bus.ir_write      = run & (st == FETCH) & bus.mem_ready;
  assign bus.pc_write_cond = run & (st == BRANCH) & (bus.zero ^ bne_q);
  assign bus.i_or_d        = run & ctl.i_or_d;
  assign bus.mem_read      = run & ctl.mem_read;
  assign bus.mem_write     = run & ctl.mem_write;
  assign bus.reg_write     = run & ctl.reg_write;
  assign bus.reg_dst       = run & ctl.reg_dst;
  assign bus.mem_to_reg    = run & ctl.mem_to_reg;
  assign bus.alu_src_a     = run & ctl.alu_src_a;
  assign bus.alu_src_b     = run ? ctl.alu_src_b : 2'd0;
  assign bus.alu_op        = run ? ctl.alu_op : 2'd0;
  assign bus.pc_src        = run ? ctl.pc_src : 2'd0;
  assign bus.ext_op        = run & ctl.ext_op;
  assign bus.illegal       = run & bad_op;
  assign bus.mem_timeout   = run & timeout;
  assign bus.retired       = run ? ret_q : '0;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Instruction-level phase model, directed table, reset corner cases and random programs.
module tb_multicycle_ctrl;
  localparam int MAXW = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_RE = 6, P_RWB = 7, P_IE = 8, P_IWB = 9, P_BR = 10, P_J = 11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_op;
    logic       illegal;
    logic       mem_timeout;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
    int         rets;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  multicycle_ctrl_if #(.RET_CNT_W(32)) bus();

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .RET_CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [31:0] rmodel  = '0;

  // Expected datapath controls for one cycle of a given instruction phase.
  function automatic outs_t exp_outs(int ph, logic [5:0] op, logic z, logic rdy, logic to);
    outs_t o;
    o = '0;
    case (ph)
      P_F:   begin o.mem_read = 1; o.alu_src_b = 2'd1; o.ir_write = rdy; o.pc_write = rdy; o.mem_timeout = to; end
      P_D: begin
        o.alu_src_b = 2'd3;
        o.ext_op    = 1;
        o.illegal   = !(op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_J} ||
                        (BNE_EN && op == OP_BNE));
      end
      P_MA:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.ext_op = 1; end
      P_MR:  begin o.mem_read = 1; o.i_or_d = 1; o.mem_timeout = to; end
      P_MWB: begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MW:  begin o.mem_write = 1; o.i_or_d = 1; o.mem_timeout = to; end
      P_RE:  begin o.alu_src_a = 1; o.alu_op = 2'd2; end
      P_RWB: begin o.reg_write = 1; o.reg_dst = 1; end
      P_IE: begin
        o.alu_src_a = 1;
        o.alu_src_b = 2'd2;
        o.ext_op    = (op == OP_ADDI);
        o.alu_op    = (op == OP_ORI) ? 2'd3 : 2'd0;
      end
      P_IWB: o.reg_write = 1;
      P_BR: begin
        o.alu_src_a = 1;
        o.alu_op = 2'd1;
        o.pc_src = 2'd1;
        o.pc_write_cond = (BNE_EN && op == OP_BNE) ? ~z : z;
      end
      P_J:   begin o.pc_write = 1; o.pc_src = 2'd2; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.ir_write      = bus.ir_write;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.reg_write     = bus.reg_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.pc_src        = bus.pc_src;
    o.ext_op        = bus.ext_op;
    o.illegal       = bus.illegal;
    o.mem_timeout   = bus.mem_timeout;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t exp, input logic [31:0] exp_ret);
    outs_t got;
    got = sample();
    vectors++;
    if (got !== exp || bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL %s @%0t: got outs=%05h retired=%0d, want outs=%05h retired=%0d",
               name, $time, got, bus.retired, exp, exp_ret);
    end
  endtask

  // One clock of one phase: drive at edge+1, check on the falling edge.
  task automatic step(input string name, input int ph, input logic [5:0] op, input logic z,
                      input logic rdy, input logic to, input bit ret);
    bit waits;
    waits = (ph == P_F || ph == P_MR || ph == P_MW);
    bus.opcode    = (ph == P_D) ? op : 6'($urandom);
    bus.zero      = (ph == P_BR) ? z : 1'($urandom);
    bus.mem_ready = waits ? rdy : 1'($urandom);
    @(negedge clk);
    chk(name, exp_outs(ph, op, z, rdy, to), rmodel);
    @(posedge clk);
    #1;
    cyc++;
    if (ret) rmodel++;
  endtask

  task automatic mem_phase(input string name, input int ph, input logic [5:0] op, input int nwait,
                           input bit ret_on_done, output bit done);
    done = 1'b0;
    for (int i = 0; i <= MAXW; i++) begin
      if (i == nwait) begin
        step(name, ph, op, 1'b0, 1'b1, 1'b0, ret_on_done);
        done = 1'b1;
        return;
      end
      step(name, ph, op, 1'b0, 1'b0, i == MAXW, 1'b0);
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit ok;
    mem_phase("fetch", P_F, op, fw, 1'b0, ok);
    if (!ok) return;
    step("decode", P_D, op, z, 1'b0, 1'b0, 1'b0);
    if (op == OP_LW || op == OP_SW) begin
      step("mem_addr", P_MA, op, z, 1'b0, 1'b0, 1'b0);
      if (op == OP_LW) begin
        mem_phase("mem_rd", P_MR, op, mw, 1'b0, ok);
        if (ok) step("mem_wb", P_MWB, op, z, 1'b0, 1'b0, 1'b1);
      end else begin
        mem_phase("mem_wr", P_MW, op, mw, 1'b1, ok);
      end
    end else if (op == OP_R) begin
      step("r_exec", P_RE, op, z, 1'b0, 1'b0, 1'b0);
      step("r_wb", P_RWB, op, z, 1'b0, 1'b0, 1'b1);
    end else if (op == OP_ADDI || op == OP_ORI) begin
      step("i_exec", P_IE, op, z, 1'b0, 1'b0, 1'b0);
      step("i_wb", P_IWB, op, z, 1'b0, 1'b0, 1'b1);
    end else if (op == OP_BEQ || (BNE_EN && op == OP_BNE)) begin
      step("branch", P_BR, op, z, 1'b0, 1'b0, 1'b1);
    end else if (op == OP_J) begin
      step("jump", P_J, op, z, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.opcode    = 6'($urandom);
      bus.zero      = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      chk("reset", '0, 32'd0);
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    rmodel = '0;
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return int'($urandom_range(MAXW - 1, MAXW + 4));
  endfunction

  initial begin
    vec_t tbl[16];
    bit ok;
    int c0;

    tbl[0]  = '{OP_R,    1'b0, 0,    0,    4,  1, "r_type"};
    tbl[1]  = '{OP_LW,   1'b0, 0,    0,    5,  1, "lw"};
    tbl[2]  = '{OP_LW,   1'b0, 0,    3,    8,  1, "lw_wait3"};
    tbl[3]  = '{OP_SW,   1'b0, 0,    0,    4,  1, "sw"};
    tbl[4]  = '{OP_SW,   1'b1, 1,    2,    7,  1, "sw_waits"};
    tbl[5]  = '{OP_ADDI, 1'b0, 0,    0,    4,  1, "addi"};
    tbl[6]  = '{OP_ORI,  1'b0, 0,    0,    4,  1, "ori"};
    tbl[7]  = '{OP_BEQ,  1'b1, 0,    0,    3,  1, "beq_taken"};
    tbl[8]  = '{OP_BEQ,  1'b0, 0,    0,    3,  1, "beq_not"};
    tbl[9]  = '{OP_J,    1'b0, 0,    0,    3,  1, "jump"};
    tbl[10] = '{OP_BAD,  1'b0, 0,    0,    2,  0, "illegal"};
    tbl[11] = '{OP_R,    1'b0, 99,   0,    16, 0, "fetch_timeout"};
    tbl[12] = '{OP_LW,   1'b0, 0,    99,   19, 0, "mem_rd_timeout"};
`ifdef MULTICYCLE_CTRL_BNE_EN
    tbl[13] = '{OP_BNE,  1'b0, 0,    0,    3,  1, "bne"};
`else
    tbl[13] = '{OP_BNE,  1'b0, 0,    0,    2,  0, "bne_illegal"};
`endif
    tbl[14] = '{OP_SW,   1'b0, 0,    MAXW, 19, 1, "sw_ready_at_limit"};
    tbl[15] = '{OP_R,    1'b0, MAXW, 0,    19, 1, "fetch_ready_at_limit"};

    rst = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    apply_reset(2);

    for (int i = 0; i < 16; i++) begin
      apply_reset(1);
      c0 = cyc;
      do_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw);
      vectors++;
      if ((cyc - c0) != tbl[i].cycles || bus.retired !== 32'(tbl[i].rets)) begin
        errors++;
        $display("FAIL table %s: got cycles=%0d retired=%0d, want cycles=%0d retired=%0d",
                 tbl[i].name, cyc - c0, bus.retired, tbl[i].cycles, tbl[i].rets);
      end
    end

    // Reset asserted while a store is waiting in MEM_WR.
    apply_reset(1);
    do_instr(OP_ADDI, 1'b0, 0, 0);
    mem_phase("fetch", P_F, OP_SW, 0, 1'b0, ok);
    step("decode", P_D, OP_SW, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mem_addr", P_MA, OP_SW, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mem_wr", P_MW, OP_SW, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mem_wr", P_MW, OP_SW, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset(1);
    do_instr(OP_J, 1'b0, 0, 0);
    do_instr(OP_R, 1'b0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 9))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_ADDI;
        4: op = OP_ORI;
        5: op = OP_BEQ;
        6: op = OP_BNE;
        7: op = OP_J;
        8: op = 6'($urandom);
        default: op = OP_LW;
      endcase
      do_instr(op, 1'($urandom), pick_wait(), pick_wait());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
